// File: rtl/ahbl_cmd_master_pkg.sv
// Shared AHB-Lite encodings and payload types for the command master.
package ahbl_cmd_master_pkg;

  localparam int unsigned AHB_AW = 16;
  localparam int unsigned AHB_DW = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_e;

  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic       HRESP_OKAY  = 1'b0;
  localparam logic       HRESP_ERROR = 1'b1;

  // Response payload captured when a data phase completes.
  typedef struct packed {
    logic [AHB_DW-1:0] rdata;
    logic              err;
  } rsp_t;

endpackage

// File: rtl/ahbl_cmd_master_if.sv
// Command/response stream and AHB-Lite initiator pins of the command master.
interface ahbl_cmd_master_if
  import ahbl_cmd_master_pkg::*;
#(
  parameter int unsigned AW = AHB_AW,
  parameter int unsigned DW = AHB_DW
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [DW-1:0] HWDATA;
  logic [DW-1:0] HRDATA;
  logic          HREADY;
  logic          HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, HRDATA, HREADY, HRESP,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           HADDR, HTRANS, HSIZE, HWRITE, HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, HRDATA, HREADY, HRESP,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           HADDR, HTRANS, HSIZE, HWRITE, HWDATA
  );
endinterface

// File: rtl/ahbl_cmd_master.sv
// Single-beat AHB-Lite initiator: address stage A overlaps data stage D,
// one NONSEQ word transfer per command and one response pulse per transfer.
module ahbl_cmd_master
  import ahbl_cmd_master_pkg::*;
#(
  parameter int unsigned AW = AHB_AW,
  parameter int unsigned DW = AHB_DW
) (
  input logic               HCLK,
  input logic               HRESETn,
  ahbl_cmd_master_if.master bus
);

  logic          a_vld_q, a_vld_d;
  logic          a_write_q, a_write_d;
  logic [AW-3:0] a_addr_q, a_addr_d;
  logic [DW-1:0] a_wdata_q, a_wdata_d;
  logic          d_vld_q, d_vld_d;
  logic          d_write_q, d_write_d;
  logic [DW-1:0] d_wdata_q, d_wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  rsp_t          rsp_q, rsp_d;
  logic          accept_c;
  logic          unused_addr_lsb;

  // Byte-lane bits are dropped: every transfer is a word.
  assign unused_addr_lsb = ^bus.cmd_addr[1:0];

  assign bus.cmd_ready = !a_vld_q || bus.HREADY;
  assign accept_c      = bus.cmd_valid && bus.cmd_ready;

  // Next-state: A advances into D on HREADY, A refills from an accepted command.
  always_comb begin
    a_vld_d     = a_vld_q;
    a_write_d   = a_write_q;
    a_addr_d    = a_addr_q;
    a_wdata_d   = a_wdata_q;
    d_vld_d     = d_vld_q;
    d_write_d   = d_write_q;
    d_wdata_d   = d_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_d       = rsp_q;

    if (bus.HREADY) begin
      d_vld_d   = a_vld_q;
      d_write_d = a_write_q;
      d_wdata_d = a_wdata_q;
      a_vld_d   = 1'b0;
    end

    if (accept_c) begin
      a_vld_d   = 1'b1;
      a_write_d = bus.cmd_write;
      a_addr_d  = bus.cmd_addr[AW-1:2];
      a_wdata_d = bus.cmd_wdata;
    end

    if (d_vld_q && bus.HREADY) begin
      rsp_valid_d = 1'b1;
      rsp_d.rdata = d_write_q ? '0 : bus.HRDATA;
      rsp_d.err   = (bus.HRESP == HRESP_ERROR);
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      a_vld_q     <= 1'b0;
      a_write_q   <= 1'b0;
      a_addr_q    <= '0;
      a_wdata_q   <= '0;
      d_vld_q     <= 1'b0;
      d_write_q   <= 1'b0;
      d_wdata_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      a_vld_q     <= a_vld_d;
      a_write_q   <= a_write_d;
      a_addr_q    <= a_addr_d;
      a_wdata_q   <= a_wdata_d;
      d_vld_q     <= d_vld_d;
      d_write_q   <= d_write_d;
      d_wdata_q   <= d_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign bus.HADDR     = {a_addr_q, 2'b00};
  assign bus.HTRANS    = a_vld_q ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HSIZE     = HSIZE_WORD;
  assign bus.HWRITE    = a_write_q;
  assign bus.HWDATA    = d_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_q.rdata;
  assign bus.rsp_err   = rsp_q.err;
  assign bus.busy      = a_vld_q || d_vld_q;

endmodule
